// File: rtl/control_unit.sv
// control_unit: Moore sequencer for a single-bus CPU datapath.
// Steps T0..T7 plus RESET and HALT; every output decodes from the registered
// state, the opcode latched at the end of T2, the memory wait counter and the
// branch-taken flag. MEM_WAIT (1..7) sets how long each memory read is held.
// Optional feature: define CU_MULDIV_EN to enable the mul/div sequences;
// without it those opcodes behave as nop and HIin/LOin/ZHighIn stay low.
module control_unit #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        PCout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  output logic        R_out,
  output logic        BAout,
  output logic        PCin,
  output logic        IRin,
  output logic        Yin,
  output logic        MARin,
  output logic        MDRin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        HIin,
  output logic        LOin,
  output logic        R_in,
  output logic        CONin,
  output logic        OutPortIn,
  output logic        Read,
  output logic        ramWE,
  output logic        IncPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        run,
  output logic [4:0]  operation
);

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
`ifdef CU_MULDIV_EN
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
`endif
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_op;
  logic [2:0] r_wait;
  logic       r_taken;

  logic       w_alu_reg;
  logic       w_alu_imm;
  logic       w_ldi;
  logic       w_ld;
  logic       w_st;
  logic       w_addr;
  logic       w_muldiv;
  logic       w_unary;
  logic       w_br;
  logic [4:0] w_imm_op;
  logic       w_unused_ir;

  // Only the opcode field of IR is ever decoded.
  assign w_unused_ir = ^IR[26:0];

  // Instruction class flags from the latched opcode.
  always_comb begin
    w_alu_reg = (r_op >= OP_ADD) && (r_op <= OP_OR);
    w_alu_imm = (r_op == OP_ADDI) || (r_op == OP_ANDI) || (r_op == OP_ORI);
    w_ldi     = (r_op == OP_LDI);
    w_ld      = (r_op == OP_LD);
    w_st      = (r_op == OP_ST);
    w_addr    = w_ldi || w_ld || w_st;
`ifdef CU_MULDIV_EN
    w_muldiv  = (r_op == OP_MUL) || (r_op == OP_DIV);
`else
    w_muldiv  = 1'b0;
`endif
    w_unary   = (r_op == OP_NEG) || (r_op == OP_NOT);
    w_br      = (r_op == OP_BR);
    w_imm_op  = '0;
    case (r_op)
      OP_ADDI: w_imm_op = OP_ADD;
      OP_ANDI: w_imm_op = OP_AND;
      OP_ORI:  w_imm_op = OP_OR;
      default: w_imm_op = '0;
    endcase
  end

  // State register, opcode latch, memory wait counter and branch-taken flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_RESET;
      r_op    <= '0;
      r_wait  <= '0;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T2) r_op <= IR[31:27];
      if ((r_state == S_T0) || ((r_state == S_T5) && w_ld))
        r_wait <= WAIT_LOAD;
      else if ((r_wait != '0) && ((r_state == S_T1) || (r_state == S_T6)))
        r_wait <= r_wait - 3'd1;
      if ((r_state == S_T5) && w_br) r_taken <= CON;
    end
  end

  // Next-state sequencing; read states stay until the wait counter reaches 0.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = (r_wait == '0) ? S_T2 : S_T1;
      S_T2:    w_next = S_T3;
      S_T3: begin
        if (r_op == OP_HALT)
          w_next = S_HALT;
        else if (w_alu_reg || w_alu_imm || w_addr || w_muldiv || w_unary || w_br)
          w_next = S_T4;
        else
          w_next = S_T0;
      end
      S_T4:    w_next = w_unary ? S_T0 : S_T5;
      S_T5:    w_next = (w_ld || w_st || w_muldiv || w_br) ? S_T6 : S_T0;
      S_T6: begin
        if (w_ld && (r_wait != '0))
          w_next = S_T6;
        else if (w_ld || w_st)
          w_next = S_T7;
        else
          w_next = S_T0;
      end
      S_T7:    w_next = S_T0;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
  end

  // Moore output decode per step and instruction class.
  always_comb begin
    PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; InPortout = 1'b0;
    R_out = 1'b0; BAout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; Yin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    ZLowIn = 1'b0; ZHighIn = 1'b0; HIin = 1'b0; LOin = 1'b0; R_in = 1'b0;
    CONin = 1'b0; OutPortIn = 1'b0;
    Read = 1'b0; ramWE = 1'b0; IncPC = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    run = (r_state != S_HALT);
    operation = '0;
    case (r_state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (w_alu_reg || w_alu_imm) begin
          Grb = 1'b1; R_out = 1'b1; Yin = 1'b1;
        end else if (w_addr) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (w_muldiv) begin
          Gra = 1'b1; R_out = 1'b1; Yin = 1'b1;
        end else if (w_unary) begin
          Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; operation = r_op;
        end else if (w_br) begin
          Gra = 1'b1; R_out = 1'b1; CONin = 1'b1;
        end else begin
          case (r_op)
            OP_JR:   begin Gra = 1'b1; R_out = 1'b1; PCin = 1'b1; end
            OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; R_out = 1'b1; OutPortIn = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (w_alu_reg) begin
          Grc = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; operation = r_op;
        end else if (w_alu_imm) begin
          Cout = 1'b1; ZLowIn = 1'b1; operation = w_imm_op;
        end else if (w_addr) begin
          Cout = 1'b1; ZLowIn = 1'b1; operation = OP_ADD;
        end else if (w_muldiv) begin
          Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; operation = r_op;
        end else if (w_unary) begin
          ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1;
        end else if (w_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      S_T5: begin
        if (w_alu_reg || w_alu_imm || w_ldi) begin
          ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1;
        end else if (w_ld || w_st) begin
          ZLowout = 1'b1; MARin = 1'b1;
        end else if (w_muldiv) begin
          ZLowout = 1'b1; LOin = 1'b1;
        end else if (w_br) begin
          Cout = 1'b1; ZLowIn = 1'b1; operation = OP_ADD;
        end
      end
      S_T6: begin
        if (w_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (w_st) begin
          Gra = 1'b1; R_out = 1'b1; MDRin = 1'b1;
        end else if (w_muldiv) begin
          ZHighout = 1'b1; HIin = 1'b1;
        end else if (w_br && r_taken) begin
          ZLowout = 1'b1; PCin = 1'b1;
        end
      end
      S_T7: begin
        if (w_ld) begin
          MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1;
        end else if (w_st) begin
          ramWE = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit. Each instruction pushes
// its expected per-cycle output vectors; they are popped and compared one per
// clock on the falling edge.
module tb_control_unit;

  localparam int unsigned MW = 3;

  // Packed output vector layout: {strobes[33:6], run[5], operation[4:0]}.
  localparam logic [33:0] PCOUT  = 34'h1 << 33;
  localparam logic [33:0] ZLOUT  = 34'h1 << 32;
  localparam logic [33:0] ZHOUT  = 34'h1 << 31;
  localparam logic [33:0] MDROUT = 34'h1 << 30;
  localparam logic [33:0] HIOUT  = 34'h1 << 29;
  localparam logic [33:0] LOOUT  = 34'h1 << 28;
  localparam logic [33:0] COUT   = 34'h1 << 27;
  localparam logic [33:0] INPOUT = 34'h1 << 26;
  localparam logic [33:0] ROUT   = 34'h1 << 25;
  localparam logic [33:0] BAOUT  = 34'h1 << 24;
  localparam logic [33:0] PCIN   = 34'h1 << 23;
  localparam logic [33:0] IRIN   = 34'h1 << 22;
  localparam logic [33:0] YIN    = 34'h1 << 21;
  localparam logic [33:0] MARIN  = 34'h1 << 20;
  localparam logic [33:0] MDRIN  = 34'h1 << 19;
  localparam logic [33:0] ZLIN   = 34'h1 << 18;
  localparam logic [33:0] ZHIN   = 34'h1 << 17;
  localparam logic [33:0] HIIN   = 34'h1 << 16;
  localparam logic [33:0] LOIN   = 34'h1 << 15;
  localparam logic [33:0] RIN    = 34'h1 << 14;
  localparam logic [33:0] CONIN  = 34'h1 << 13;
  localparam logic [33:0] OPIN   = 34'h1 << 12;
  localparam logic [33:0] READ   = 34'h1 << 11;
  localparam logic [33:0] RAMWE  = 34'h1 << 10;
  localparam logic [33:0] INCPC  = 34'h1 << 9;
  localparam logic [33:0] GRA    = 34'h1 << 8;
  localparam logic [33:0] GRB    = 34'h1 << 7;
  localparam logic [33:0] GRC    = 34'h1 << 6;
  localparam logic [33:0] RUN    = 34'h1 << 5;

  logic clk, clr, CON;
  logic [31:0] IR;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout, R_out, BAout;
  logic PCin, IRin, Yin, MARin, MDRin, ZLowIn, ZHighIn, HIin, LOin, R_in, CONin, OutPortIn;
  logic Read, ramWE, IncPC, Gra, Grb, Grc, run;
  logic [4:0] operation;
  logic [33:0] obs;

  control_unit #(.MEM_WAIT(MW)) dut (
    .clk(clk), .clr(clr), .IR(IR), .CON(CON),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
    .R_out(R_out), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .Yin(Yin), .MARin(MARin), .MDRin(MDRin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin), .R_in(R_in),
    .CONin(CONin), .OutPortIn(OutPortIn),
    .Read(Read), .ramWE(ramWE), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .run(run), .operation(operation)
  );

  assign obs = {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
                R_out, BAout, PCin, IRin, Yin, MARin, MDRin, ZLowIn, ZHighIn,
                HIin, LOin, R_in, CONin, OutPortIn, Read, ramWE, IncPC,
                Gra, Grb, Grc, run, operation};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [33:0] v;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned n_read;
  int unsigned n_ramwe;

  task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [33:0] mask, input logic [4:0] op);
    exp_t e;
    e.tag = tag;
    e.v   = mask | RUN | 34'(op);
    sb.push_back(e);
  endtask

  task automatic push_halt(input string tag);
    exp_t e;
    e.tag = tag;
    e.v   = '0;
    sb.push_back(e);
  endtask

  task automatic push_fetch(input string n);
    push({n, ".T0"}, PCOUT | MARIN | INCPC, 5'd0);
    for (int unsigned i = 0; i < MW; i++) push({n, ".T1"}, READ | MDRIN, 5'd0);
    push({n, ".T2"}, MDROUT | IRIN, 5'd0);
  endtask

  task automatic start(input logic [4:0] opc, input logic con);
    IR  = {opc, 27'($urandom)};
    CON = con;
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq(e.tag, obs, e.v);
      if (Read)  n_read++;
      if (ramWE) n_ramwe++;
      @(negedge clk);
    end
  endtask

  task automatic alu_reg(input string n, input logic [4:0] opc);
    start(opc, 1'b0);
    push_fetch(n);
    push({n, ".T3"}, GRB | ROUT | YIN, 5'd0);
    push({n, ".T4"}, GRC | ROUT | ZLIN, opc);
    push({n, ".T5"}, ZLOUT | GRA | RIN, 5'd0);
    drain();
  endtask

  task automatic alu_imm(input string n, input logic [4:0] opc, input logic [4:0] aop);
    start(opc, 1'b0);
    push_fetch(n);
    push({n, ".T3"}, GRB | ROUT | YIN, 5'd0);
    push({n, ".T4"}, COUT | ZLIN, aop);
    push({n, ".T5"}, ZLOUT | GRA | RIN, 5'd0);
    drain();
  endtask

  task automatic one_step(input string n, input logic [4:0] opc, input logic [33:0] m3);
    start(opc, 1'b0);
    push_fetch(n);
    push({n, ".T3"}, m3, 5'd0);
    drain();
  endtask

  task automatic unary(input string n, input logic [4:0] opc);
    start(opc, 1'b0);
    push_fetch(n);
    push({n, ".T3"}, GRB | ROUT | ZLIN, opc);
    push({n, ".T4"}, ZLOUT | GRA | RIN, 5'd0);
    drain();
  endtask

  task automatic muldiv(input string n, input logic [4:0] opc);
`ifdef CU_MULDIV_EN
    start(opc, 1'b0);
    push_fetch(n);
    push({n, ".T3"}, GRA | ROUT | YIN, 5'd0);
    push({n, ".T4"}, GRB | ROUT | ZLIN | ZHIN, opc);
    push({n, ".T5"}, ZLOUT | LOIN, 5'd0);
    push({n, ".T6"}, ZHOUT | HIIN, 5'd0);
    drain();
`else
    one_step(n, opc, '0);
`endif
  endtask

  task automatic branch(input string n, input logic con);
    start(5'b10011, con);
    push_fetch(n);
    push({n, ".T3"}, GRA | ROUT | CONIN, 5'd0);
    push({n, ".T4"}, PCOUT | YIN, 5'd0);
    push({n, ".T5"}, COUT | ZLIN, 5'b00011);
    push({n, ".T6"}, con ? (ZLOUT | PCIN) : 34'h0, 5'd0);
    drain();
  endtask

  task automatic addr_prefix(input string n);
    push({n, ".T3"}, GRB | BAOUT | YIN, 5'd0);
    push({n, ".T4"}, COUT | ZLIN, 5'b00011);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; n_read = 0; n_ramwe = 0;
    clr = 1'b1; IR = '0; CON = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    push("reset", '0, 5'd0);
    drain();

    alu_reg("add", 5'b00011);
    alu_reg("sub", 5'b00100);
    alu_reg("or",  5'b01011);
    alu_imm("addi", 5'b01100, 5'b00011);
    alu_imm("andi", 5'b01101, 5'b01010);
    alu_imm("ori",  5'b01110, 5'b01011);

    start(5'b00001, 1'b0);
    push_fetch("ldi");
    addr_prefix("ldi");
    push("ldi.T5", ZLOUT | GRA | RIN, 5'd0);
    drain();

    n_read = 0;
    start(5'b00000, 1'b0);
    push_fetch("ld");
    addr_prefix("ld");
    push("ld.T5", ZLOUT | MARIN, 5'd0);
    for (int unsigned i = 0; i < MW; i++) push("ld.T6", READ | MDRIN, 5'd0);
    push("ld.T7", MDROUT | GRA | RIN, 5'd0);
    drain();
    check_eq("ld.read_cycles", 34'(n_read), 34'(2 * MW));

    n_ramwe = 0;
    start(5'b00010, 1'b0);
    push_fetch("st");
    addr_prefix("st");
    push("st.T5", ZLOUT | MARIN, 5'd0);
    push("st.T6", GRA | ROUT | MDRIN, 5'd0);
    push("st.T7", RAMWE, 5'd0);
    drain();
    check_eq("st.ramwe_cycles", 34'(n_ramwe), 34'd1);

    unary("neg", 5'b10001);
    unary("not", 5'b10010);
    muldiv("mul", 5'b10000);
    muldiv("div", 5'b01111);
    branch("br0", 1'b0);
    branch("br1", 1'b1);
    one_step("jr",   5'b10100, GRA | ROUT | PCIN);
    one_step("in",   5'b10110, INPOUT | GRA | RIN);
    one_step("out",  5'b10111, GRA | ROUT | OPIN);
    one_step("mfhi", 5'b11000, HIOUT | GRA | RIN);
    one_step("mflo", 5'b11001, LOOUT | GRA | RIN);
    one_step("nop",  5'b11010, '0);
    one_step("op15", 5'b10101, '0);
    one_step("op1f", 5'b11111, '0);

    // Store aborted by clr while in T6.
    n_ramwe = 0;
    start(5'b00010, 1'b0);
    push_fetch("sta");
    addr_prefix("sta");
    push("sta.T5", ZLOUT | MARIN, 5'd0);
    drain();
    clr = 1'b1;
    push("sta.T6", GRA | ROUT | MDRIN, 5'd0);
    push("sta.rst1", '0, 5'd0);
    drain();
    clr = 1'b0;
    push("sta.rst2", '0, 5'd0);
    drain();
    check_eq("sta.ramwe_cycles", 34'(n_ramwe), 34'd0);
    alu_reg("add2", 5'b00011);

    // Halt, IR change while halted, then restart via clr.
    start(5'b11011, 1'b0);
    push_fetch("halt");
    push("halt.T3", '0, 5'd0);
    for (int unsigned i = 0; i < 3; i++) push_halt("halt.hold");
    drain();
    IR = {5'b00011, 27'($urandom)};
    for (int unsigned i = 0; i < 5; i++) push_halt("halt.irchg");
    drain();
    clr = 1'b1;
    push_halt("halt.clr");
    drain();
    clr = 1'b0;
    push("halt.reset", '0, 5'd0);
    push("halt.T0", PCOUT | MARIN | INCPC, 5'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
